alu_arbiter: RTL

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin arbiter that shares one external ALU between two requesters.
// Each operation walks IDLE (grant) -> EXEC (ALU driven) -> RESP (held until consumed).
module alu_arbiter #(
   parameter int DATA_W = 32,
   parameter int OP_W   = 4,
   parameter int CNT_W  = 16
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [1:0]          ReqValid,
   output logic [1:0]          ReqReady,
   input  logic [2*OP_W-1:0]   ReqOp,
   input  logic [2*DATA_W-1:0] ReqA,
   input  logic [2*DATA_W-1:0] ReqB,
   output logic [OP_W-1:0]     ALUControl,
   output logic [DATA_W-1:0]   ALUA,
   output logic [DATA_W-1:0]   ALUB,
   input  logic [DATA_W-1:0]   ALUResult,
   input  logic                ALUZero,
   output logic                RespValid,
   input  logic                RespReady,
   output logic                RespId,
   output logic [DATA_W-1:0]   RespResult,
   output logic                RespZero,
   output logic                RespErr,
   output logic [CNT_W-1:0]    OpCount
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   localparam logic [OP_W-1:0] LAST_LEGAL_OP = OP_W'(8);

   state_t              state;
   state_t              state_nxt;
   logic                last_grant;
   logic                grant_id;
   logic [1:0]          grant;
   logic                id_p0;
   logic                req_hs;
   logic                resp_hs;
   logic                op_ok;
   logic [OP_W-1:0]     sel_op;
   logic [DATA_W-1:0]   sel_a;
   logic [DATA_W-1:0]   sel_b;

   function automatic logic op_legal(input logic [OP_W-1:0] op);
      return (op <= LAST_LEGAL_OP);
   endfunction

   // Illegal ops report a forced zero result with the zero flag set.
   function automatic logic [DATA_W-1:0] resp_result_f(input logic legal,
                                                       input logic [DATA_W-1:0] res);
      return legal ? res : '0;
   endfunction

   function automatic logic resp_zero_f(input logic legal, input logic zero);
      return legal ? zero : 1'b1;
   endfunction

   // Grant only in IDLE; on a tie the port not granted last time wins.
   always_comb begin
      grant    = 2'b00;
      grant_id = 1'b0;
      if (state == IDLE && !reset) begin
         case (ReqValid)
            2'b01: begin
               grant    = 2'b01;
               grant_id = 1'b0;
            end
            2'b10: begin
               grant    = 2'b10;
               grant_id = 1'b1;
            end
            2'b11: begin
               grant_id = ~last_grant;
               grant    = last_grant ? 2'b01 : 2'b10;
            end
            default: begin
               grant    = 2'b00;
               grant_id = 1'b0;
            end
         endcase
      end
   end

   assign ReqReady  = grant;
   assign req_hs    = |(ReqValid & ReqReady);
   assign resp_hs   = (state == RESP) && RespReady;
   assign RespValid = (state == RESP);
   assign op_ok     = op_legal(ALUControl);

   assign sel_op = grant_id ? ReqOp[2*OP_W-1:OP_W]     : ReqOp[OP_W-1:0];
   assign sel_a  = grant_id ? ReqA[2*DATA_W-1:DATA_W]  : ReqA[DATA_W-1:0];
   assign sel_b  = grant_id ? ReqB[2*DATA_W-1:DATA_W]  : ReqB[DATA_W-1:0];

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (req_hs) state_nxt = EXEC;
         EXEC:    state_nxt = RESP;
         RESP:    if (RespReady) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         last_grant <= 1'b1;
         id_p0      <= 1'b0;
         ALUControl <= '0;
         ALUA       <= '0;
         ALUB       <= '0;
         RespId     <= 1'b0;
         RespResult <= '0;
         RespZero   <= 1'b0;
         RespErr    <= 1'b0;
         OpCount    <= '0;
      end else begin
         state <= state_nxt;
         // p0: accepted request is latched straight onto the ALU operand registers
         if (req_hs) begin
            last_grant <= grant_id;
            id_p0      <= grant_id;
            ALUControl <= sel_op;
            ALUA       <= sel_a;
            ALUB       <= sel_b;
         end
         // p1: ALU output captured at the end of EXEC and held through RESP
         if (state == EXEC) begin
            RespId     <= id_p0;
            RespResult <= resp_result_f(op_ok, ALUResult);
            RespZero   <= resp_zero_f(op_ok, ALUZero);
            RespErr    <= ~op_ok;
         end
         if (resp_hs) begin
            OpCount <= OpCount + CNT_W'(1);
         end
      end
   end

endmodule
